// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution path.
//
// Contents:
//   PC_WIDTH      - instruction address width used by the slot struct.
//   slot_t        - one pipeline slot of prediction state:
//                   {valid, pc, pred_taken, pred_target}.
//   is_mispredict - compares a slot's prediction with the actual EX outcome.
package bp_pkg;

  localparam int PC_WIDTH = 32;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } slot_t;

  // A prediction is wrong when:
  //   - a conditional branch went the other direction,
  //   - a taken branch went somewhere other than the predicted target, or
  //   - a non-branch was predicted taken (stale BTB alias).
  // The slot's valid bit is not looked at here; the caller qualifies it.
  function automatic logic is_mispredict(input slot_t               s,
                                         input logic                is_branch,
                                         input logic                taken,
                                         input logic [PC_WIDTH-1:0] target);
    logic wrong;
    if (is_branch) begin
      wrong = (s.pred_taken != taken) ||
              (s.pred_taken && taken && (s.pred_target != target));
    end else begin
      wrong = s.pred_taken;
    end
    return wrong;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter.
//
// Ports:
//   clk    - clock, counts on the rising edge.
//   rst_n  - synchronous active-low clear.
//   en     - increment request for this edge.
//   count  - current value; sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit.
//
// Carries each fetched instruction's prediction through two slots (ID, EX),
// compares it with the actual outcome when the instruction resolves in EX,
// redirects fetch / flushes younger work on a mispredict, and one cycle
// later drives the BHT/BTB write port. Also keeps saturating counters of
// resolved branches and of redirects.
//
// Parameters:
//   PC_WIDTH  - instruction address width; the slot struct is sized by
//               bp_pkg::PC_WIDTH, so this must stay equal to it.
//   CNT_WIDTH - width of branch_cnt / mispred_cnt.
//
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset.
//   pc_if, pred_taken_if,
//   pred_target_if                - IF instruction and its prediction.
//   stall_if_id, stall_id_ex      - hold the ID / EX slot.
//   ex_is_branch, ex_taken,
//   ex_target                     - actual outcome of the EX instruction.
//   redirect, redirect_pc, flush  - combinational mispredict response.
//   bht_write, btb_write, upd_pc,
//   upd_taken, upd_target         - registered predictor update (1 cycle).
//   branch_cnt, mispred_cnt       - saturating performance counters.
module branch_resolve_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  pc_if,
  input  logic                 pred_taken_if,
  input  logic [PC_WIDTH-1:0]  pred_target_if,
  input  logic                 stall_if_id,
  input  logic                 stall_id_ex,
  input  logic                 ex_is_branch,
  input  logic                 ex_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic                 redirect,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic                 bht_write,
  output logic                 btb_write,
  output logic [PC_WIDTH-1:0]  upd_pc,
  output logic                 upd_taken,
  output logic [PC_WIDTH-1:0]  upd_target,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  import bp_pkg::*;

  slot_t id_slot;
  slot_t ex_slot;
  slot_t if_slot;

  logic  resolve;
  logic  mispred;
  logic  branch_resolved;
  logic  upd_fire;

  // Incoming IF instruction packed as a slot.
  always_comb begin
    if_slot             = '0;
    if_slot.valid       = 1'b1;
    if_slot.pc          = pc_if;
    if_slot.pred_taken  = pred_taken_if;
    if_slot.pred_target = pred_target_if;
  end

  // An instruction resolves only when it is real and allowed to leave EX.
  assign resolve         = ex_slot.valid && !stall_id_ex;
  assign mispred         = resolve &&
                           is_mispredict(ex_slot, ex_is_branch, ex_taken, ex_target);
  assign branch_resolved = resolve && ex_is_branch;

  // Something is written to the predictors for every resolved branch and for
  // a non-branch that hit a stale BTB entry (so the entry gets invalidated).
  assign upd_fire = resolve && (ex_is_branch || ex_slot.pred_taken);

  // Mispredict response. redirect_pc is forced to zero when not redirecting
  // so it is quiet out of reset and between mispredicts.
  always_comb begin
    redirect    = mispred;
    flush       = mispred;
    redirect_pc = '0;
    if (mispred) begin
      if (ex_is_branch && ex_taken) begin
        redirect_pc = ex_target;
      end else begin
        redirect_pc = ex_slot.pc + PC_WIDTH'(4);
      end
    end
  end

  // Slot pipeline. A redirect kills both slots (and the instruction that IF
  // presents this cycle) regardless of stalls. stall_id_ex=1 holds both
  // slots, which also absorbs the illegal stall_if_id=0/stall_id_ex=1 case.
  // With only ID held, EX drains and takes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || mispred) begin
      id_slot <= '0;
      ex_slot <= '0;
    end else if (!stall_id_ex) begin
      if (stall_if_id) begin
        ex_slot <= '0;
      end else begin
        ex_slot <= id_slot;
        id_slot <= if_slot;
      end
    end
  end

  // Predictor update stage, one cycle after resolution. The strobes are
  // recomputed every edge so each pulse lasts exactly one cycle; the data
  // fields hold their last value between updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bht_write  <= 1'b0;
      btb_write  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
    end else begin
      bht_write <= branch_resolved;
      // Taken branches train the BTB; an aliased non-branch invalidates it.
      btb_write <= resolve && (ex_is_branch ? ex_taken : ex_slot.pred_taken);
      if (upd_fire) begin
        upd_pc     <= ex_slot.pc;
        upd_taken  <= ex_is_branch && ex_taken;
        upd_target <= ex_is_branch ? ex_target : ex_slot.pred_target;
      end
    end
  end

  bp_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (branch_resolved),
    .count (branch_cnt)
  );

  bp_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mispred),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit, built with 4-bit counters so
// saturation is reachable quickly. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later, well away from the edge.
module tb_branch_resolve_unit;

  localparam int PW = 32;
  localparam int CW = 4;
  localparam logic [PW-1:0] FILL_PC = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pc_if;
  logic          pred_taken_if;
  logic [PW-1:0] pred_target_if;
  logic          stall_if_id;
  logic          stall_id_ex;
  logic          ex_is_branch;
  logic          ex_taken;
  logic [PW-1:0] ex_target;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          flush;
  logic          bht_write;
  logic          btb_write;
  logic [PW-1:0] upd_pc;
  logic          upd_taken;
  logic [PW-1:0] upd_target;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_unit #(
    .PC_WIDTH  (PW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .pred_taken_if  (pred_taken_if),
    .pred_target_if (pred_target_if),
    .stall_if_id    (stall_if_id),
    .stall_id_ex    (stall_id_ex),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .bht_write      (bht_write),
    .btb_write      (btb_write),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [PW-1:0] pc, input logic pt, input logic [PW-1:0] tgt);
    pc_if          = pc;
    pred_taken_if  = pt;
    pred_target_if = tgt;
  endtask

  task automatic ex_none();
    ex_is_branch = 1'b0;
    ex_taken     = 1'b0;
    ex_target    = '0;
  endtask

  task automatic ex_br(input logic taken, input logic [PW-1:0] tgt);
    ex_is_branch = 1'b1;
    ex_taken     = taken;
    ex_target    = tgt;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    rst_n       = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    fetch(FILL_PC, 1'b0, '0);
    ex_none();
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_redirect",    32'(redirect),    32'd0);
    chk("rst_flush",       32'(flush),       32'd0);
    chk("rst_redirect_pc", redirect_pc,      32'd0);
    chk("rst_bht_write",   32'(bht_write),   32'd0);
    chk("rst_btb_write",   32'(btb_write),   32'd0);
    chk("rst_upd_pc",      upd_pc,           32'd0);
    chk("rst_upd_target",  upd_target,       32'd0);
    chk("rst_upd_taken",   32'(upd_taken),   32'd0);
    chk("rst_branch_cnt",  32'(branch_cnt),  32'd0);
    chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);

    // Correct not-taken at 0x100
    fetch(32'h100, 1'b0, '0);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b0, 32'h0);
    #1;
    chk("nt_redirect", 32'(redirect), 32'd0);
    chk("nt_flush",    32'(flush),    32'd0);
    step();
    ex_none();
    #1;
    chk("nt_bht_write",  32'(bht_write),  32'd1);
    chk("nt_btb_write",  32'(btb_write),  32'd0);
    chk("nt_upd_pc",     upd_pc,          32'h100);
    chk("nt_upd_taken",  32'(upd_taken),  32'd0);
    chk("nt_branch_cnt", 32'(branch_cnt), 32'd1);

    // Direction mispredict at 0x200: predicted not-taken, actually taken to 0x80
    fetch(32'h200, 1'b0, '0);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'h80);
    fetch(32'h208, 1'b1, 32'h5000);  // discarded by the flush
    #1;
    chk("dir_redirect",    32'(redirect), 32'd1);
    chk("dir_redirect_pc", redirect_pc,   32'h80);
    chk("dir_flush",       32'(flush),    32'd1);
    step();
    // EX must now be empty: a taken-branch outcome must not redirect.
    ex_br(1'b1, 32'h999);
    fetch(FILL_PC, 1'b0, '0);
    #1;
    chk("dir_ex_flushed",  32'(redirect),    32'd0);
    chk("dir_bht_write",   32'(bht_write),   32'd1);
    chk("dir_btb_write",   32'(btb_write),   32'd1);
    chk("dir_upd_pc",      upd_pc,           32'h200);
    chk("dir_upd_taken",   32'(upd_taken),   32'd1);
    chk("dir_upd_target",  upd_target,       32'h80);
    chk("dir_mispred_cnt", 32'(mispred_cnt), 32'd1);
    chk("dir_branch_cnt",  32'(branch_cnt),  32'd2);
    step();
    // ID was flushed too (and the discarded 0x208 never entered it).
    #1;
    chk("dir_id_flushed", 32'(redirect),  32'd0);
    chk("dir_no_update",  32'(bht_write), 32'd0);
    ex_none();

    // Target mispredict: predicted taken to 0x300, actually taken to 0x340
    fetch(32'h2F0, 1'b1, 32'h300);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'h340);
    #1;
    chk("tgt_redirect",    32'(redirect), 32'd1);
    chk("tgt_redirect_pc", redirect_pc,   32'h340);
    step();
    ex_none();
    #1;
    chk("tgt_btb_write",   32'(btb_write),   32'd1);
    chk("tgt_upd_target",  upd_target,       32'h340);
    chk("tgt_mispred_cnt", 32'(mispred_cnt), 32'd2);
    chk("tgt_branch_cnt",  32'(branch_cnt),  32'd3);

    // Correctly predicted taken branch: no redirect, BTB and BHT both written
    fetch(32'h2F8, 1'b1, 32'h300);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'h300);
    #1;
    chk("tk_redirect", 32'(redirect), 32'd0);
    step();
    ex_none();
    #1;
    chk("tk_bht_write",   32'(bht_write),   32'd1);
    chk("tk_btb_write",   32'(btb_write),   32'd1);
    chk("tk_upd_pc",      upd_pc,           32'h2F8);
    chk("tk_upd_taken",   32'(upd_taken),   32'd1);
    chk("tk_mispred_cnt", 32'(mispred_cnt), 32'd2);
    chk("tk_branch_cnt",  32'(branch_cnt),  32'd4);

    // BTB alias: non-branch at 0x400 predicted taken
    fetch(32'h400, 1'b1, 32'h480);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_none();
    #1;
    chk("alias_redirect",    32'(redirect), 32'd1);
    chk("alias_redirect_pc", redirect_pc,   32'h404);
    step();
    #1;
    chk("alias_btb_write",   32'(btb_write),   32'd1);
    chk("alias_bht_write",   32'(bht_write),   32'd0);
    chk("alias_upd_taken",   32'(upd_taken),   32'd0);
    chk("alias_upd_pc",      upd_pc,           32'h400);
    chk("alias_mispred_cnt", 32'(mispred_cnt), 32'd3);
    chk("alias_branch_cnt",  32'(branch_cnt),  32'd4);

    // Stall with a mispredicted branch sitting in EX
    fetch(32'h600, 1'b0, '0);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'h700);
    stall_if_id = 1'b1;
    stall_id_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_no_redirect", 32'(redirect),  32'd0);
      chk("stall_no_update",   32'(bht_write), 32'd0);
      step();
    end
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    #1;
    chk("stall_redirect",    32'(redirect), 32'd1);
    chk("stall_redirect_pc", redirect_pc,   32'h700);
    step();
    #1;
    chk("stall_once_redirect", 32'(redirect),    32'd0);
    chk("stall_bht_write",     32'(bht_write),   32'd1);
    chk("stall_upd_pc",        upd_pc,           32'h600);
    chk("stall_mispred_cnt",   32'(mispred_cnt), 32'd4);
    chk("stall_branch_cnt",    32'(branch_cnt),  32'd5);
    ex_none();
    step();
    #1;
    chk("stall_single_update", 32'(bht_write), 32'd0);

    // ID held while EX drains: EX takes a bubble, branch resolves later
    fetch(32'h800, 1'b0, '0);
    step();
    stall_if_id = 1'b1;
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'h900);
    #1;
    chk("bubble_no_redirect", 32'(redirect), 32'd0);
    stall_if_id = 1'b0;
    step();
    #1;
    chk("bubble_redirect",    32'(redirect), 32'd1);
    chk("bubble_redirect_pc", redirect_pc,   32'h900);
    step();
    ex_none();
    #1;
    chk("bubble_mispred_cnt", 32'(mispred_cnt), 32'd5);
    chk("bubble_branch_cnt",  32'(branch_cnt),  32'd6);

    // Saturation: 20 more mispredicted branches
    for (int i = 0; i < 20; i++) begin
      fetch(32'hA00 + 32'(i * 16), 1'b0, '0);
      step();
      fetch(FILL_PC, 1'b0, '0);
      step();
      ex_br(1'b1, 32'hB00);
      step();
      ex_none();
      if (i == 8) begin
        #1;
        chk("sat_mid_mispred_cnt", 32'(mispred_cnt), 32'd14);
        chk("sat_mid_branch_cnt",  32'(branch_cnt),  32'd15);
      end
    end
    #1;
    chk("sat_mispred_cnt", 32'(mispred_cnt), 32'hF);
    chk("sat_branch_cnt",  32'(branch_cnt),  32'hF);

    // Reset while an update is pending
    fetch(32'hC00, 1'b0, '0);
    step();
    fetch(FILL_PC, 1'b0, '0);
    step();
    ex_br(1'b1, 32'hD00);
    #1;
    chk("rp_redirect", 32'(redirect), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ex_none();
    #1;
    chk("rp_bht_write",   32'(bht_write),   32'd0);
    chk("rp_btb_write",   32'(btb_write),   32'd0);
    chk("rp_upd_pc",      upd_pc,           32'd0);
    chk("rp_upd_target",  upd_target,       32'd0);
    chk("rp_upd_taken",   32'(upd_taken),   32'd0);
    chk("rp_redirect_0",  32'(redirect),    32'd0);
    chk("rp_redirect_pc", redirect_pc,      32'd0);
    chk("rp_branch_cnt",  32'(branch_cnt),  32'd0);
    chk("rp_mispred_cnt", 32'(mispred_cnt), 32'd0);
    step();
    #1;
    chk("rp_no_late_update", 32'(bht_write), 32'd0);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks each fetched instruction's branch prediction from IF through ID to EX and compares it with the actual outcome when the instruction resolves in EX. On a mismatch it redirects fetch and flushes younger instructions. One cycle after resolution it drives the write port of the BHT and BTB predictors. It sits between the fetch-stage predictors (BHT/BTB lookup) and the EX-stage branch unit, and keeps saturating branch and misprediction counters.

## Interface
Parameters:
- PC_WIDTH, 32, instruction address width.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous and active-low (sampled on the rising edge of clk).
- pc_if  in  PC_WIDTH  PC of the instruction in IF.
- pred_taken_if  in  1  the predictors (BHT and BTB) predict this fetched instruction taken.
- pred_target_if  in  PC_WIDTH  predicted target; meaningful only when pred_taken_if=1.
- stall_if_id  in  1  hold the IF/ID slot.
- stall_id_ex  in  1  hold the ID/EX slot.
- ex_is_branch  in  1  the EX instruction is a conditional branch.
- ex_taken  in  1  actual branch outcome.
- ex_target  in  PC_WIDTH  actual branch target.
- redirect  out  1  misprediction; fetch must load redirect_pc next edge.
- redirect_pc  out  PC_WIDTH  corrected fetch PC.
- flush  out  1  invalidate IF/ID and ID/EX instructions (equals redirect).
- bht_write  out  1  BHT update strobe.
- btb_write  out  1  BTB update strobe.
- upd_pc  out  PC_WIDTH  branch PC being updated.
- upd_taken  out  1  actual outcome for the BHT.
- upd_target  out  PC_WIDTH  target for the BTB.
- branch_cnt  out  CNT_WIDTH  resolved branches.
- mispred_cnt  out  CNT_WIDTH  redirects issued.

## Operation
- Two internal slots, ID and EX. Each slot holds: valid, pc, pred_taken, pred_target.
- Each edge without stall_id_ex: the EX slot takes the ID slot.
- Each edge without stall_if_id: the ID slot takes {1, pc_if, pred_taken_if, pred_target_if}.
- Stall, either slot: the slot holds its contents.
- stall_if_id=0 while stall_id_ex=1: not permitted; treat it as a hold of both slots.
- Stall, EX slot only (stall_id_ex=1 while stall_if_id=0 is the illegal case above): when stall_id_ex=0 but the EX slot must drain while ID holds, the EX slot takes an invalid bubble.
- Resolution occurs only when EX slot.valid=1 and stall_id_ex=0.
- Misprediction is any of:
  - branch with pred_taken != ex_taken;
  - branch with pred_taken=ex_taken=1 and pred_target != ex_target;
  - non-branch with pred_taken=1 (BTB alias).
- redirect_pc:
  - ex_taken ? ex_target : pc+4 for a branch;
  - pc+4 for a non-branch alias. Addition is modulo 2^PC_WIDTH.
- On redirect:
  - both slots become invalid at the next edge, overriding any stall;
  - the instruction captured from IF that cycle is discarded.
- Update stage (registered):
  - a resolved branch sets bht_write=1 in the next cycle, with upd_pc, upd_taken, upd_target;
  - btb_write=1 only if the branch was taken;
  - a non-branch alias sets btb_write=1 with upd_taken=0, telling the BTB to invalidate the entry; bht_write stays 0.
- Counters:
  - branch_cnt +1 per resolved branch;
  - mispred_cnt +1 per redirect;
  - both saturate at all-ones, never wrapping.
- Reset:
  - all slots invalid;
  - redirect, flush, bht_write, btb_write = 0;
  - redirect_pc, upd_pc, upd_target = 0; upd_taken = 0;
  - counters = 0.
  - Reset asserted mid-operation discards any pending update.

## Timing
- redirect, flush and redirect_pc are combinational from the EX slot and the EX inputs, valid in the resolution cycle.
- Update outputs are asserted exactly 1 cycle after resolution, for 1 cycle.
- Back-to-back resolutions give back-to-back update pulses.
- Counters update at the resolution edge and are visible the next cycle.
- Prediction-to-resolution latency is 2 cycles minimum; stalls extend it.

## Structure
- Shared package bp_pkg:
  - PC_WIDTH;
  - a slot struct {valid, pc, pred_taken, pred_target};
  - a function computing the mispredict condition.
- One natural sub-module: bp_sat_counter (CNT_WIDTH, increment enable, synchronous active-low reset), instantiated twice.

## Test plan
- Correct not-taken: pred_taken_if=0 at pc 0x100; two cycles later ex_is_branch=1, ex_taken=0 -> redirect=0. Next cycle: bht_write=1, upd_pc=0x100, upd_taken=0, btb_write=0. branch_cnt=1.
- Direction mispredict: pred 0 at pc 0x200; ex_taken=1, ex_target=0x80 -> redirect=1, redirect_pc=0x80, flush=1, both slots invalid next cycle. Then bht_write=1, btb_write=1, upd_target=0x80. mispred_cnt=1.
- Target mispredict: pred taken to 0x300; actual taken to 0x340 -> redirect_pc=0x340.
- Alias: non-branch at pc 0x400 with pred_taken=1 -> redirect_pc=0x404, btb_write=1, upd_taken=0, bht_write=0.
- Stall: stall_id_ex=1 for 3 cycles with a mispredicted branch in EX -> no redirect until the stall drops, then exactly one redirect and one update.
- Saturation/reset: preload counters near all-ones (CNT_WIDTH=4), 20 mispredicts -> both counters hold at 0xF. Then rst_n=0 for one edge while an update is pending -> all outputs 0 and no bht_write.
